// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the instruction memory loader
package imem_loader_pkg;

  localparam int HEADER_LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    LANE0,
    LANE1,
    LANE2,
    LANE3
  } lane_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - 8->32 little-endian lane register with byte counter
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_full
);

  // word_full is high for the cycle after the fourth lane is filled
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      word      <= '0;
      byte_idx  <= LANE0;
      word_full <= 1'b0;
    end else begin
      word_full <= byte_valid && (byte_idx == LANE3);
      if (byte_valid) begin
        word[8*byte_idx +: 8] <= byte_data;
        byte_idx              <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream writer for instruction memory, holds the core in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int LEN_WIDTH = HEADER_LEN_WIDTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_write_enable,
  output logic [31:0] imem_write_address,
  output logic [31:0] imem_write_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                 state;
  state_t                 state_next;
  logic [LEN_WIDTH-1:0]   len;
  logic [IDX_WIDTH-1:0]   word_idx;
  logic                   accepting;
  logic                   hs;
  logic [15:0]            hdr_len;
  logic                   hdr_ok;
  logic                   last_word;
  logic [31:0]            packed_word;
  logic [1:0]             byte_idx;
  logic                   word_full;
  logic                   pack_valid;
  logic                   pack_clear;

  assign accepting = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign in_ready  = accepting;
  assign hs        = in_valid && accepting;

  // Full header as it will look once the high byte lands this cycle
  assign hdr_len   = {in_data, len[7:0]};
  assign hdr_ok    = (hdr_len != 16'd0) && (int'(hdr_len) <= DEPTH);
  assign last_word = (int'(word_idx) == int'(len) - 1);

  assign pack_valid = hs && (state == S_DATA);
  assign pack_clear = hs && (state == S_LEN_HI) && hdr_ok;

  word_packer u_word_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word       (packed_word),
    .byte_idx   (byte_idx),
    .word_full  (word_full)
  );

  // word_idx only advances at the end of WRITE, so it is stable for the whole write cycle
  assign imem_write_address = {{(32-IDX_WIDTH-2){1'b0}}, word_idx, 2'b00};
  assign imem_write_data    = packed_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    busy              = 1'b0;
    cpu_reset         = 1'b1;
    done              = 1'b0;
    error             = 1'b0;
    imem_write_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        busy = 1'b1;
        if (hs) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        busy = 1'b1;
        if (hs) state_next = hdr_ok ? S_DATA : S_ERROR;
      end
      S_DATA: begin
        busy = 1'b1;
        if (hs && (byte_idx == LANE3)) state_next = S_WRITE;
      end
      S_WRITE: begin
        busy              = 1'b1;
        imem_write_enable = word_full;
        state_next        = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_next = S_LEN_LO;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_LEN_LO;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len      <= '0;
      word_idx <= '0;
    end else begin
      if (hs && (state == S_LEN_LO)) begin
        len[7:0] <= in_data;
      end
      if (hs && (state == S_LEN_HI)) begin
        len      <= LEN_WIDTH'(hdr_len);
        word_idx <= '0;
      end
      if ((state == S_WRITE) && !last_word) begin
        word_idx <= word_idx + IDX_WIDTH'(1);
      end
    end
  end

endmodule
